mips_mc_control: RTL and testbench

- Multicycle MIPS main control FSM: the producer end of the ALU's ALUControl/operand-select interface.
- Decodes Op/Funct from the instruction register and sequences fetch/decode/execute/memory/writeback.
- Drives ALUControl, operand muxes and all write enables of the multicycle datapath.
- Waits on a memory-ready handshake during fetch and data-memory access.

---
 rtl/mips_pkg.sv | 56 +++++
 rtl/mips_mc_control_alu_decoder.sv | 38 +++
 rtl/mips_mc_control.sv | 209 ++++++++++++++++++++
 tb/tb_mips_mc_control.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multicycle MIPS control path.
// Holds the opcode and funct constants, the ALUControl encodings, the ALUOp
// selector used by the ALU decoder and the main-control state enum.
// Optional feature macro: MIPS_MC_ADDI_EN adds the ADDIEX/ADDIWB states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1000;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXECUTE = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
`ifdef MIPS_MC_ADDI_EN
    S_JUMP    = 4'd10,
    S_ADDIEX  = 4'd11,
    S_ADDIWB  = 4'd12
`else
    S_JUMP    = 4'd10
`endif
  } state_e;

endpackage

// File: rtl/mips_mc_control_alu_decoder.sv
// mips_alu_decoder: combinational ALUOp + Funct -> ALUControl.
// Ports:
//   alu_op_i      ALUOP_ADD -> ADD, ALUOP_SUB -> SUB, ALUOP_FUNCT -> decode funct_i
//   funct_i       instruction[5:0]
//   alu_control_o ALU operation encoding
//   illegal_o     high only when decoding Funct and Funct is unsupported
import mips_pkg::*;

module mips_alu_decoder (
  input  aluop_e      alu_op_i,
  input  logic [5:0]  funct_i,
  output logic [3:0]  alu_control_o,
  output logic        illegal_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    illegal_o     = 1'b0;
    case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_AND:  alu_control_o = ALU_AND;
          FN_OR:   alu_control_o = ALU_OR;
          FN_ADD:  alu_control_o = ALU_ADD;
          FN_XOR:  alu_control_o = ALU_XOR;
          FN_SUB:  alu_control_o = ALU_SUB;
          FN_SLT:  alu_control_o = ALU_SLT;
          FN_NOR:  alu_control_o = ALU_NOR;
          // Unsupported funct falls back to ADD and is flagged.
          default: illegal_o = 1'b1;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// mips_mc_control: multicycle MIPS main control FSM.
// Sequences fetch/decode/execute/memory/writeback, drives operand selects,
// ALUControl and all datapath write enables, and waits on MemReady during
// instruction fetch and data-memory access.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   Op, Funct         instruction fields from the instruction register
//   Zero              ALU zero flag (used in BRANCH)
//   MemReady          memory completes the current access this cycle
//   IorD..PCEn        datapath selects and enables
//   IllegalOp         one-cycle pulse on unsupported Op/Funct
//   Busy              high in every state except IDLE
//   dbg_state_o       current FSM state for observation
// Handshake: MemRead/MemWrite and IorD are held stable in FETCH/MEMRD/MEMWR
// until a cycle where MemReady is high; that cycle completes the access and
// the FSM advances on the following edge.
// Optional feature macro: MIPS_MC_ADDI_EN (addi support).
import mips_pkg::*;

module mips_mc_control #(
  parameter int unsigned RESET_PC_HOLD = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  Op,
  input  logic [5:0]  Funct,
  input  logic        Zero,
  input  logic        MemReady,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUControl,
  output logic [1:0]  PCSrc,
  output logic        PCEn,
  output logic        IllegalOp,
  output logic        Busy,
  output state_e      dbg_state_o
);

  state_e     state_q, state_d;
  logic [3:0] idle_cnt_q, idle_cnt_d;
  logic       idle_done;
  aluop_e     alu_op;
  logic [3:0] dec_alu_control;
  logic       dec_illegal;

  // IDLE always lasts at least one cycle, even with RESET_PC_HOLD = 0.
  assign idle_done = (32'(idle_cnt_q) + 32'd1) >= RESET_PC_HOLD;

  // ALUOp depends on state only, keeping the decoder out of any feedback path.
  always_comb begin
    alu_op = ALUOP_ADD;
    if (state_q == S_EXECUTE)     alu_op = ALUOP_FUNCT;
    else if (state_q == S_BRANCH) alu_op = ALUOP_SUB;
  end

  mips_alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct_i       (Funct),
    .alu_control_o (dec_alu_control),
    .illegal_o     (dec_illegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      idle_cnt_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = dec_alu_control;
    PCSrc      = 2'b00;
    PCEn       = 1'b0;
    IllegalOp  = 1'b0;
    Busy       = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (idle_done) state_d = S_FETCH;
        else           idle_cnt_d = idle_cnt_q + 4'd1;
      end
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCEn    = MemReady;
        if (MemReady) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch target into ALUOut.
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MIPS_MC_ADDI_EN
          OP_ADDI:      state_d = S_ADDIEX;
`endif
          default: begin
            IllegalOp = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (MemReady) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        // Unsupported funct: flag it and skip the writeback entirely.
        if (dec_illegal) begin
          IllegalOp = 1'b1;
          state_d   = S_FETCH;
        end else begin
          state_d   = S_ALUWB;
        end
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        PCSrc   = 2'b01;
        PCEn    = Zero;
        state_d = S_FETCH;
      end
      S_JUMP: begin
        PCSrc   = 2'b10;
        PCEn    = 1'b1;
        state_d = S_FETCH;
      end
`ifdef MIPS_MC_ADDI_EN
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Reset masks every output to its IDLE value in the same cycle, so an
    // abandoned instruction cannot commit a write on the reset edge.
    if (reset) begin
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUControl = ALU_ADD;
      PCSrc      = 2'b00;
      PCEn       = 1'b0;
      IllegalOp  = 1'b0;
      Busy       = 1'b0;
    end
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
`timescale 1ns/1ps
module tb_mips_mc_control;
  import mips_pkg::*;

  localparam int W = 19;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Op = 6'd0;
  logic [5:0] Funct = 6'd0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b1;
  logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [3:0] ALUControl;
  logic       PCEn, IllegalOp, Busy;
  state_e     dbg_state;

  always #5 clk = ~clk;

  mips_mc_control #(.RESET_PC_HOLD(1)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero), .MemReady(MemReady),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCSrc(PCSrc), .PCEn(PCEn),
    .IllegalOp(IllegalOp), .Busy(Busy), .dbg_state_o(dbg_state)
  );

  logic [W-1:0] obs;
  assign obs = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                ALUSrcB, ALUControl, PCSrc, PCEn, IllegalOp, Busy};

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mr;
  } stim_t;

  stim_t        stim_q[$];
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           failures = 0;

  // Expected output vector, field order matches obs.
  function automatic logic [W-1:0] v(
    input logic iord, input logic memrd, input logic memwr, input logic irw,
    input logic regdst, input logic m2r, input logic regw, input logic srca,
    input logic [1:0] srcb, input logic [3:0] alu, input logic [1:0] pcsrc,
    input logic pcen, input logic ill, input logic busy);
    return {iord, memrd, memwr, irw, regdst, m2r, regw, srca, srcb, alu, pcsrc, pcen, ill, busy};
  endfunction

  function automatic logic [W-1:0] e_idle();
    return v(0,0,0,0,0,0,0,0,2'b00,4'b0010,2'b00,0,0,0);
  endfunction
  function automatic logic [W-1:0] e_fetch(input logic mr);
    return v(0,1,0,mr,0,0,0,0,2'b01,4'b0010,2'b00,mr,0,1);
  endfunction
  function automatic logic [W-1:0] e_decode(input logic ill);
    return v(0,0,0,0,0,0,0,0,2'b11,4'b0010,2'b00,0,ill,1);
  endfunction
  function automatic logic [W-1:0] e_memadr();
    return v(0,0,0,0,0,0,0,1,2'b10,4'b0010,2'b00,0,0,1);
  endfunction
  function automatic logic [W-1:0] e_memrd();
    return v(1,1,0,0,0,0,0,0,2'b00,4'b0010,2'b00,0,0,1);
  endfunction
  function automatic logic [W-1:0] e_memwb();
    return v(0,0,0,0,0,1,1,0,2'b00,4'b0010,2'b00,0,0,1);
  endfunction
  function automatic logic [W-1:0] e_memwr();
    return v(1,0,1,0,0,0,0,0,2'b00,4'b0010,2'b00,0,0,1);
  endfunction
  function automatic logic [W-1:0] e_exec(input logic [3:0] alu, input logic ill);
    return v(0,0,0,0,0,0,0,1,2'b00,alu,2'b00,0,ill,1);
  endfunction
  function automatic logic [W-1:0] e_aluwb();
    return v(0,0,0,0,1,0,1,0,2'b00,4'b0010,2'b00,0,0,1);
  endfunction
  function automatic logic [W-1:0] e_branch(input logic z);
    return v(0,0,0,0,0,0,0,1,2'b00,4'b0110,2'b01,z,0,1);
  endfunction
  function automatic logic [W-1:0] e_jump();
    return v(0,0,0,0,0,0,0,0,2'b00,4'b0010,2'b10,1,0,1);
  endfunction
`ifdef MIPS_MC_ADDI_EN
  function automatic logic [W-1:0] e_addiex();
    return v(0,0,0,0,0,0,0,1,2'b10,4'b0010,2'b00,0,0,1);
  endfunction
  function automatic logic [W-1:0] e_addiwb();
    return v(0,0,0,0,0,0,1,0,2'b00,4'b0010,2'b00,0,0,1);
  endfunction
`endif

  // ---------------- driver tasks ----------------
  task automatic push(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                      input logic z, input logic mr, input logic [W-1:0] e);
    stim_t s;
    s.rst = rst; s.op = op; s.funct = fn; s.zero = z; s.mr = mr;
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Random don't-care funct/zero for cycles where they must not matter.
  function automatic logic [5:0] rfn();
    return 6'($urandom_range(0, 63));
  endfunction
  function automatic logic rz();
    return 1'($urandom_range(0, 1));
  endfunction

  // Inputs applied just after a rising edge, outputs observed at the falling edge.
  task automatic drive_cycle(input stim_t s);
    reset    = s.rst;
    Op       = s.op;
    Funct    = s.funct;
    Zero     = s.zero;
    MemReady = s.mr;
    @(negedge clk);
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] e;
    int n = 0;
    for (int i = 0; i < 3; i++) push(1, OP_J, rfn(), rz(), 1, e_idle());
    push(0, OP_J, rfn(), rz(), 1, e_idle());
    push(0, OP_J, rfn(), rz(), 1, e_fetch(1));
    push(0, OP_J, rfn(), rz(), 1, e_decode(0));
    push(0, OP_J, rfn(), rz(), 1, e_jump());
    while (exp_q.size() != 0) begin
      drive_cycle(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL reset cyc=%0d got=%b exp=%b", n, obs, e);
      end
      next_edge();
      n++;
    end
  endtask

  task automatic test_lw();
    logic [W-1:0] e;
    int n = 0;
    push(0, OP_LW, rfn(), rz(), 1, e_fetch(1));
    push(0, OP_LW, rfn(), rz(), 1, e_decode(0));
    push(0, OP_LW, rfn(), rz(), 1, e_memadr());
    push(0, OP_LW, rfn(), rz(), 1, e_memrd());
    push(0, OP_LW, rfn(), rz(), 1, e_memwb());
    // Second lw with a fetch stall and a data-read stall.
    push(0, OP_LW, rfn(), rz(), 0, e_fetch(0));
    push(0, OP_LW, rfn(), rz(), 1, e_fetch(1));
    push(0, OP_LW, rfn(), rz(), 1, e_decode(0));
    push(0, OP_LW, rfn(), rz(), 1, e_memadr());
    push(0, OP_LW, rfn(), rz(), 0, e_memrd());
    push(0, OP_LW, rfn(), rz(), 1, e_memrd());
    push(0, OP_LW, rfn(), rz(), 1, e_memwb());
    while (exp_q.size() != 0) begin
      drive_cycle(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL lw cyc=%0d got=%b exp=%b", n, obs, e);
      end
      next_edge();
      n++;
    end
  endtask

  task automatic test_rtype();
    logic [W-1:0] e;
    logic [5:0]   fn_tab [8];
    logic [3:0]   alu_tab[8];
    int n = 0;
    fn_tab[0] = 6'b100100; alu_tab[0] = 4'b0000;
    fn_tab[1] = 6'b100101; alu_tab[1] = 4'b0001;
    fn_tab[2] = 6'b100000; alu_tab[2] = 4'b0010;
    fn_tab[3] = 6'b100110; alu_tab[3] = 4'b0011;
    fn_tab[4] = 6'b100010; alu_tab[4] = 4'b0110;
    fn_tab[5] = 6'b101010; alu_tab[5] = 4'b0111;
    fn_tab[6] = 6'b100111; alu_tab[6] = 4'b1000;
    fn_tab[7] = 6'b111111; alu_tab[7] = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      push(0, OP_RTYPE, fn_tab[i], rz(), 1, e_fetch(1));
      push(0, OP_RTYPE, fn_tab[i], rz(), 1, e_decode(0));
      if (i == 7) begin
        push(0, OP_RTYPE, fn_tab[i], rz(), 1, e_exec(alu_tab[i], 1));
      end else begin
        push(0, OP_RTYPE, fn_tab[i], rz(), 1, e_exec(alu_tab[i], 0));
        push(0, OP_RTYPE, fn_tab[i], rz(), 1, e_aluwb());
      end
    end
    while (exp_q.size() != 0) begin
      drive_cycle(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL rtype cyc=%0d funct=%b got=%b exp=%b", n, Funct, obs, e);
      end
      next_edge();
      n++;
    end
  endtask

  task automatic test_beq();
    logic [W-1:0] e;
    int n = 0;
    for (int z = 1; z >= 0; z--) begin
      push(0, OP_BEQ, rfn(), rz(), 1, e_fetch(1));
      push(0, OP_BEQ, rfn(), rz(), 1, e_decode(0));
      push(0, OP_BEQ, rfn(), 1'(z), 1, e_branch(1'(z)));
    end
    while (exp_q.size() != 0) begin
      drive_cycle(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL beq cyc=%0d got=%b exp=%b", n, obs, e);
      end
      next_edge();
      n++;
    end
  endtask

  task automatic test_sw_stall();
    logic [W-1:0] e;
    int n = 0;
    push(0, OP_SW, rfn(), rz(), 1, e_fetch(1));
    push(0, OP_SW, rfn(), rz(), 1, e_decode(0));
    push(0, OP_SW, rfn(), rz(), 1, e_memadr());
    push(0, OP_SW, rfn(), rz(), 0, e_memwr());
    push(0, OP_SW, rfn(), rz(), 0, e_memwr());
    push(0, OP_SW, rfn(), rz(), 1, e_memwr());
    // Reset in the middle of a stalled store.
    push(0, OP_SW, rfn(), rz(), 1, e_fetch(1));
    push(0, OP_SW, rfn(), rz(), 1, e_decode(0));
    push(0, OP_SW, rfn(), rz(), 1, e_memadr());
    push(0, OP_SW, rfn(), rz(), 0, e_memwr());
    push(1, OP_SW, rfn(), rz(), 0, e_idle());
    push(0, OP_J,  rfn(), rz(), 1, e_idle());
    push(0, OP_J,  rfn(), rz(), 1, e_fetch(1));
    push(0, OP_J,  rfn(), rz(), 1, e_decode(0));
    push(0, OP_J,  rfn(), rz(), 1, e_jump());
    while (exp_q.size() != 0) begin
      drive_cycle(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL sw_stall cyc=%0d got=%b exp=%b", n, obs, e);
      end
      next_edge();
      n++;
    end
  endtask

  task automatic test_addi();
    logic [W-1:0] e;
    int n = 0;
    push(0, OP_ADDI, rfn(), rz(), 1, e_fetch(1));
`ifdef MIPS_MC_ADDI_EN
    push(0, OP_ADDI, rfn(), rz(), 1, e_decode(0));
    push(0, OP_ADDI, rfn(), rz(), 1, e_addiex());
    push(0, OP_ADDI, rfn(), rz(), 1, e_addiwb());
`else
    push(0, OP_ADDI, rfn(), rz(), 1, e_decode(1));
`endif
    push(0, OP_J, rfn(), rz(), 1, e_fetch(1));
    push(0, OP_J, rfn(), rz(), 1, e_decode(0));
    push(0, OP_J, rfn(), rz(), 1, e_jump());
    while (exp_q.size() != 0) begin
      drive_cycle(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL addi cyc=%0d got=%b exp=%b", n, obs, e);
      end
      next_edge();
      n++;
    end
  endtask

  task automatic test_illegal_op();
    logic [W-1:0] e;
    logic [5:0]   bad[3];
    int n = 0;
    bad[0] = 6'b111111; bad[1] = 6'b000011; bad[2] = 6'b100001;
    for (int i = 0; i < 3; i++) begin
      push(0, bad[i], rfn(), rz(), 1, e_fetch(1));
      push(0, bad[i], rfn(), rz(), 1, e_decode(1));
    end
    push(0, OP_BEQ, rfn(), rz(), 1, e_fetch(1));
    push(0, OP_BEQ, rfn(), rz(), 1, e_decode(0));
    push(0, OP_BEQ, rfn(), 1'b0, 1, e_branch(0));
    while (exp_q.size() != 0) begin
      drive_cycle(stim_q.pop_front());
      e = exp_q.pop_front();
      checks++;
      if (obs !== e) begin
        failures++;
        $display("FAIL illegal_op cyc=%0d op=%b got=%b exp=%b", n, Op, obs, e);
      end
      next_edge();
      n++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_sw_stall();
    test_addi();
    test_illegal_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
